// File: rtl/pdm_modulator.sv
// pdm_modulator: PCM-to-PDM transmitter, 2-entry sample buffer feeding a 2nd-order saturating sigma-delta loop.
// Optional feature macro: PDM_MOD_DITHER_EN adds +/-1 LSB LFSR dither to the loop input.
module pdm_modulator #(
    parameter int DATA_W     = 16,
    parameter int ACC1_W     = 20,
    parameter int ACC2_W     = 24,
    parameter int MUTE_TICKS = 64
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              en_i,
    input  logic              mclear,
    input  logic              ce_pdm,
    input  logic              ce_pcm,
    input  logic [DATA_W-1:0] pcm_data_i,
    input  logic              pcm_valid_i,
    output logic              pcm_ready_o,
    output logic              pdm_data_o,
    output logic              busy_o,
    output logic              underrun_o,
    output logic              sat_o,
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_MUTE = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(MUTE_TICKS + 1);
    localparam int S1_W  = ACC1_W + 2;
    localparam int S2_W  = ACC2_W + 2;

    localparam logic signed [S1_W-1:0] I1_MAX  = {3'b000, {(ACC1_W-1){1'b1}}};
    localparam logic signed [S1_W-1:0] I1_MIN  = {3'b111, {(ACC1_W-1){1'b0}}};
    localparam logic signed [S2_W-1:0] I2_MAX  = {3'b000, {(ACC2_W-1){1'b1}}};
    localparam logic signed [S2_W-1:0] I2_MIN  = {3'b111, {(ACC2_W-1){1'b0}}};
    localparam logic signed [S1_W-1:0] FB1_POS = {{(S1_W-DATA_W){1'b0}}, 1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [S1_W-1:0] FB1_NEG = {{(S1_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [S2_W-1:0] FB2_POS = {{(S2_W-DATA_W){1'b0}}, 1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [S2_W-1:0] FB2_NEG = {{(S2_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    state_t                    state_q, state_d;
    logic [DATA_W-1:0]         mem_q [2];
    logic [DATA_W-1:0]         mem_d [2];
    logic                      wr_ptr_q, wr_ptr_d;
    logic                      rd_ptr_q, rd_ptr_d;
    logic [1:0]                count_q, count_d;
    logic                      ready_q, ready_d;
    logic signed [DATA_W-1:0]  x_cur_q, x_cur_d;
    logic signed [ACC1_W-1:0]  i1_q, i1_d;
    logic signed [ACC2_W-1:0]  i2_q, i2_d;
    logic                      pdm_q, pdm_d;
    logic                      und_q, und_d;
    logic                      sat_q, sat_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;

    logic                      push, pop;
    logic signed [DATA_W:0]    xin;
    logic signed [S1_W-1:0]    fb1, sum1;
    logic signed [S2_W-1:0]    fb2, sum2;
    logic signed [ACC1_W-1:0]  i1_new;
    logic signed [ACC2_W-1:0]  i2_new;
    logic                      clamp1, clamp2;

`ifdef PDM_MOD_DITHER_EN
    logic [15:0]               lfsr_q, lfsr_d;
    localparam logic [15:0]    LFSR_SEED = 16'hACE1;
`endif

    // Loop datapath: feedback is the previous output bit, integrator 2 sees the already-clamped i1.
    always_comb begin
        xin = (state_q == ST_RUN) ? {x_cur_q[DATA_W-1], x_cur_q} : '0;
`ifdef PDM_MOD_DITHER_EN
        xin = xin + {{DATA_W{lfsr_q[0]}}, 1'b1};
`endif
        fb1 = pdm_q ? FB1_POS : FB1_NEG;
        fb2 = pdm_q ? FB2_POS : FB2_NEG;
        sum1 = {{2{i1_q[ACC1_W-1]}}, i1_q} + {{(S1_W-DATA_W-1){xin[DATA_W]}}, xin} - fb1;
        i1_new = sum1[ACC1_W-1:0];
        clamp1 = 1'b0;
        if (sum1 > I1_MAX) begin
            i1_new = I1_MAX[ACC1_W-1:0];
            clamp1 = 1'b1;
        end else if (sum1 < I1_MIN) begin
            i1_new = I1_MIN[ACC1_W-1:0];
            clamp1 = 1'b1;
        end
        sum2 = {{2{i2_q[ACC2_W-1]}}, i2_q} + {{(S2_W-ACC1_W){i1_new[ACC1_W-1]}}, i1_new} - fb2;
        i2_new = sum2[ACC2_W-1:0];
        clamp2 = 1'b0;
        if (sum2 > I2_MAX) begin
            i2_new = I2_MAX[ACC2_W-1:0];
            clamp2 = 1'b1;
        end else if (sum2 < I2_MIN) begin
            i2_new = I2_MIN[ACC2_W-1:0];
            clamp2 = 1'b1;
        end
    end

    // Handshake: a sample transfers on a cycle where pcm_valid_i and pcm_ready_o are both high;
    // pcm_ready_o depends only on registered occupancy, never combinationally on pcm_valid_i.
    always_comb begin
        state_d  = state_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        x_cur_d  = x_cur_q;
        i1_d     = i1_q;
        i2_d     = i2_q;
        pdm_d    = pdm_q;
        und_d    = und_q;
        sat_d    = sat_q;
        cnt_d    = cnt_q;
`ifdef PDM_MOD_DITHER_EN
        lfsr_d   = ce_pdm ? ({1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000)) : lfsr_q;
`endif

        push = pcm_valid_i & ready_q & ~mclear;
        pop  = ce_pcm & (state_q == ST_RUN) & (count_q != 2'd0);

        if (ce_pcm && (state_q == ST_RUN) && (count_q == 2'd0)) und_d = 1'b1;
        if (pop) begin
            x_cur_d  = mem_q[rd_ptr_q];
            rd_ptr_d = ~rd_ptr_q;
        end
        if (push) begin
            mem_d[wr_ptr_q] = pcm_data_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};

        if (ce_pdm) begin
            if (state_q == ST_IDLE) begin
                pdm_d = ~pdm_q;
            end else begin
                i1_d  = i1_new;
                i2_d  = i2_new;
                pdm_d = ~i2_new[ACC2_W-1];
                if (clamp1 || clamp2) sat_d = 1'b1;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                i1_d = '0;
                i2_d = '0;
                if (en_i) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!en_i) begin
                    state_d = ST_MUTE;
                    cnt_d   = CNT_W'(MUTE_TICKS);
                end
            end
            ST_MUTE: begin
                if (en_i) begin
                    state_d = ST_RUN;
                end else if (ce_pdm) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        i1_d    = '0;
                        i2_d    = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (mclear) begin
            state_d  = ST_IDLE;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
            x_cur_d  = '0;
            i1_d     = '0;
            i2_d     = '0;
            pdm_d    = 1'b0;
            und_d    = 1'b0;
            sat_d    = 1'b0;
            cnt_d    = '0;
`ifdef PDM_MOD_DITHER_EN
            lfsr_d   = LFSR_SEED;
`endif
        end
        ready_d = (count_d != 2'd2);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q  <= ST_IDLE;
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            ready_q  <= 1'b1;
            x_cur_q  <= '0;
            i1_q     <= '0;
            i2_q     <= '0;
            pdm_q    <= 1'b0;
            und_q    <= 1'b0;
            sat_q    <= 1'b0;
            cnt_q    <= '0;
`ifdef PDM_MOD_DITHER_EN
            lfsr_q   <= LFSR_SEED;
`endif
        end else begin
            state_q  <= state_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            x_cur_q  <= x_cur_d;
            i1_q     <= i1_d;
            i2_q     <= i2_d;
            pdm_q    <= pdm_d;
            und_q    <= und_d;
            sat_q    <= sat_d;
            cnt_q    <= cnt_d;
`ifdef PDM_MOD_DITHER_EN
            lfsr_q   <= lfsr_d;
`endif
        end
    end

    assign pcm_ready_o = ready_q;
    assign pdm_data_o  = pdm_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign underrun_o  = und_q;
    assign sat_o       = sat_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pdm_modulator.sv
// tb_pdm_modulator: directed bench for pdm_modulator with a cycle model of the loop and sample buffer.
module tb_pdm_modulator;

    logic        clk;
    logic        rst_n;
    logic        en_i, mclear, ce_pdm, ce_pcm;
    logic [15:0] pcm_data_i;
    logic        pcm_valid_i;
    logic        pcm_ready_o, pdm_data_o, busy_o, underrun_o, sat_o;
    logic [1:0]  dbg_state_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          m_state, m_x, m_i1, m_i2, m_cnt;
    bit          m_pdm, m_sat, m_und, m_ready;
    logic [15:0] exp_q[$];

    pdm_modulator dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .en_i        (en_i),
        .mclear      (mclear),
        .ce_pdm      (ce_pdm),
        .ce_pcm      (ce_pcm),
        .pcm_data_i  (pcm_data_i),
        .pcm_valid_i (pcm_valid_i),
        .pcm_ready_o (pcm_ready_o),
        .pdm_data_o  (pdm_data_o),
        .busy_o      (busy_o),
        .underrun_o  (underrun_o),
        .sat_o       (sat_o),
        .dbg_state_o (dbg_state_o)
    );

    // Clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, expected end before time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_x = 0; m_i1 = 0; m_i2 = 0; m_cnt = 0;
        m_pdm = 1'b0; m_sat = 1'b0; m_und = 1'b0; m_ready = 1'b1;
        exp_q.delete();
    endtask

    // One clock; model advances with the inputs the DUT saw at this edge.
    task automatic step();
        bit push, pop;
        int xin, fb, n1, n2;
        logic signed [15:0] sv;
        @(posedge clk);
        #1;
        if (mclear) begin
            m_state = 0; m_x = 0; m_i1 = 0; m_i2 = 0; m_cnt = 0;
            m_pdm = 1'b0; m_sat = 1'b0; m_und = 1'b0;
            exp_q.delete();
        end else begin
            push = pcm_valid_i && m_ready;
            pop  = ce_pcm && (m_state == 1) && (exp_q.size() > 0);
            if (ce_pcm && (m_state == 1) && (exp_q.size() == 0)) m_und = 1'b1;
            if (ce_pdm) begin
                if (m_state == 0) begin
                    m_pdm = !m_pdm;
                end else begin
                    xin = (m_state == 1) ? m_x : 0;
                    fb  = m_pdm ? 32768 : -32768;
                    n1  = m_i1 + xin - fb;
                    if (n1 > 524287) begin n1 = 524287; m_sat = 1'b1; end
                    if (n1 < -524288) begin n1 = -524288; m_sat = 1'b1; end
                    n2  = m_i2 + n1 - fb;
                    if (n2 > 8388607) begin n2 = 8388607; m_sat = 1'b1; end
                    if (n2 < -8388608) begin n2 = -8388608; m_sat = 1'b1; end
                    m_i1 = n1; m_i2 = n2; m_pdm = (n2 >= 0);
                end
            end
            case (m_state)
                0: if (en_i) m_state = 1;
                1: if (!en_i) begin m_state = 2; m_cnt = 64; end
                default: begin
                    if (en_i) m_state = 1;
                    else if (ce_pdm) begin
                        m_cnt--;
                        if (m_cnt == 0) begin m_state = 0; m_i1 = 0; m_i2 = 0; end
                    end
                end
            endcase
            if (pop) begin
                sv  = exp_q.pop_front();
                m_x = sv;
            end
            if (push) exp_q.push_back(pcm_data_i);
        end
        m_ready = (exp_q.size() < 2);
    endtask

    // n PDM ticks (one tick every 2 clocks), a PCM strobe every pcm_div ticks.
    task automatic run_ticks(input int n, input int pcm_div,
                             output int ones_dut, output int ones_mod, output int mism);
        ones_dut = 0; ones_mod = 0; mism = 0;
        for (int t = 0; t < n; t++) begin
            ce_pdm = 1'b1;
            ce_pcm = ((t % pcm_div) == 0);
            step();
            ce_pdm = 1'b0;
            ce_pcm = 1'b0;
            if (pdm_data_o !== m_pdm) mism++;
            if (pdm_data_o === 1'b1) ones_dut++;
            if (m_pdm) ones_mod++;
            step();
        end
    endtask

    task automatic do_mclear();
        mclear = 1'b1; en_i = 1'b0; pcm_valid_i = 1'b0;
        step();
        mclear = 1'b0;
    endtask

    initial begin
        int od, om, mm, fell;
        rst_n = 1'b0; en_i = 1'b0; mclear = 1'b0; ce_pdm = 1'b0; ce_pcm = 1'b0;
        pcm_data_i = '0; pcm_valid_i = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        step();
        check("rst_ready", pcm_ready_o, 1);
        check("rst_pdm", pdm_data_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_underrun", underrun_o, 0);
        check("rst_sat", sat_o, 0);
        check("rst_state", dbg_state_o, 0);

        // Zero input: balanced density
        pcm_data_i = 16'h0000; pcm_valid_i = 1'b1; en_i = 1'b1;
        step();
        check("t1_state_run", dbg_state_o, 1);
        run_ticks(1024, 8, od, om, mm);
        check("t1_density_window", (od >= 496 && od <= 528), 1);
        check("t1_ones_vs_model", od, om);
        check("t1_bit_mismatches", mm, 0);
        check("t1_underrun", underrun_o, 0);
        check("t1_sat", sat_o, 0);

        // Half scale positive then negative
        pcm_data_i = 16'h4000;
        run_ticks(256, 8, od, om, mm);
        run_ticks(1024, 8, od, om, mm);
        check("t2_pos_density_window", (od >= 752 && od <= 784), 1);
        check("t2_pos_ones_vs_model", od, om);
        check("t2_pos_bit_mismatches", mm, 0);
        pcm_data_i = 16'hC000;
        run_ticks(256, 8, od, om, mm);
        run_ticks(1024, 8, od, om, mm);
        check("t2_neg_density_window", (od >= 240 && od <= 272), 1);
        check("t2_neg_ones_vs_model", od, om);
        check("t2_neg_bit_mismatches", mm, 0);
        check("t2_sat_vs_model", sat_o, m_sat);
        check("t2_underrun", underrun_o, 0);

        // Buffer fills to two, order preserved
        do_mclear();
        check("t3_mclear_state", dbg_state_o, 0);
        check("t3_mclear_pdm", pdm_data_o, 0);
        pcm_valid_i = 1'b1; pcm_data_i = 16'h1234;
        step();
        check("t3_ready_after_one", pcm_ready_o, 1);
        pcm_data_i = 16'h5678;
        step();
        check("t3_full_not_ready", pcm_ready_o, 0);
        pcm_data_i = 16'h9ABC;
        step();
        check("t3_still_not_ready", pcm_ready_o, 0);
        pcm_valid_i = 1'b0; en_i = 1'b1;
        step();
        ce_pcm = 1'b1; step(); ce_pcm = 1'b0;
        check("t3_pop1_value", {16'h0, dut.x_cur_q}, 32'h1234);
        check("t3_ready_after_pop", pcm_ready_o, 1);
        step();
        ce_pcm = 1'b1; step(); ce_pcm = 1'b0;
        check("t3_pop2_value", {16'h0, dut.x_cur_q}, 32'h5678);

        // Underrun on empty buffer, then cleared
        ce_pcm = 1'b1; step(); ce_pcm = 1'b0;
        check("t4_underrun_set", underrun_o, 1);
        check("t4_x_held", {16'h0, dut.x_cur_q}, 32'h5678);
        check("t4_busy", busy_o, 1);
        mclear = 1'b1; en_i = 1'b0; pcm_valid_i = 1'b1; pcm_data_i = 16'h1111;
        step();
        mclear = 1'b0; pcm_valid_i = 1'b0;
        check("t4_mclear_underrun", underrun_o, 0);
        check("t4_mclear_idle", dbg_state_o, 0);
        check("t4_mclear_ready", pcm_ready_o, 1);
        en_i = 1'b1; step();
        ce_pcm = 1'b1; step(); ce_pcm = 1'b0;
        check("t4_push_dropped_underrun", underrun_o, 1);
        check("t4_push_dropped_x", {16'h0, dut.x_cur_q}, 32'h0);

        // Negative full scale: integrator 2 pinned at its minimum
        do_mclear();
        pcm_valid_i = 1'b1; pcm_data_i = 16'h8000;
        step();
        en_i = 1'b1; step();
        ce_pcm = 1'b1; step(); ce_pcm = 1'b0;
        check("t5_x_min_loaded", {16'h0, dut.x_cur_q}, 32'h8000);
        run_ticks(512, 8, od, om, mm);
        check("t5_neg_sat", sat_o, 1);
        check("t5_neg_i2_min", {8'h0, dut.i2_q}, 32'h0080_0000);
        check("t5_neg_bit_mismatches", mm, 0);

        // Positive full scale against the model
        do_mclear();
        check("t5_mclear_sat", sat_o, 0);
        pcm_valid_i = 1'b1; pcm_data_i = 16'h7FFF;
        step();
        en_i = 1'b1; step();
        ce_pcm = 1'b1; step(); ce_pcm = 1'b0;
        run_ticks(4096, 8, od, om, mm);
        check("t5_pos_bit_mismatches", mm, 0);
        check("t5_pos_ones_vs_model", od, om);
        check("t5_pos_sat_vs_model", sat_o, m_sat);
        check("t5_pos_i1_vs_model", {12'h0, dut.i1_q}, 32'(m_i1) & 32'h000F_FFFF);
        check("t5_pos_i2_vs_model", {8'h0, dut.i2_q}, 32'(m_i2) & 32'h00FF_FFFF);

        // Mute tail length
        do_mclear();
        pcm_valid_i = 1'b1; pcm_data_i = 16'h0000; en_i = 1'b1;
        step();
        run_ticks(64, 8, od, om, mm);
        en_i = 1'b0;
        step();
        check("t6_mute_state", dbg_state_o, 2);
        check("t6_mute_busy", busy_o, 1);
        fell = 0;
        for (int k = 1; k <= 80; k++) begin
            ce_pdm = 1'b1; step(); ce_pdm = 1'b0;
            if (busy_o === 1'b0 && fell == 0) fell = k;
            step();
        end
        check("t6_mute_ticks", fell, 64);
        check("t6_idle_i1_cleared", {12'h0, dut.i1_q}, 32'h0);
        ce_pdm = 1'b1; step(); ce_pdm = 1'b0;
        check("t6_idle_toggle_a", pdm_data_o, m_pdm);
        ce_pdm = 1'b1; step(); ce_pdm = 1'b0;
        check("t6_idle_toggle_b", pdm_data_o, m_pdm);

        // Asynchronous reset in the middle of RUN
        do_mclear();
        en_i = 1'b1; pcm_valid_i = 1'b1; pcm_data_i = 16'h2000;
        step();
        step();
        pcm_valid_i = 1'b0;
        repeat (3) begin ce_pcm = 1'b1; step(); end
        ce_pcm = 1'b0;
        pcm_valid_i = 1'b1;
        step();
        step();
        check("t6_pre_underrun", underrun_o, 1);
        check("t6_pre_ready", pcm_ready_o, 0);
        check("t6_pre_busy", busy_o, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_pdm", pdm_data_o, 0);
        check("t6_rst_busy", busy_o, 0);
        check("t6_rst_underrun", underrun_o, 0);
        check("t6_rst_sat", sat_o, 0);
        check("t6_rst_ready", pcm_ready_o, 1);
        check("t6_rst_state", dbg_state_o, 0);
        en_i = 1'b0; pcm_valid_i = 1'b0;
        model_reset();
        #2 rst_n = 1'b1;
        step();
        check("t6_after_rst_idle", busy_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
